// File: rtl/io_bus_ctrl.sv
// Data-side bus controller: decodes CPU loads/stores into the data RAM or a small
// memory-mapped I/O file holding LED, switch, timer/compare and interrupt status.
module io_bus_ctrl #(
   parameter int unsigned RAM_AW = 12,
   parameter int unsigned SW_W   = 16
) (
   input  logic              clk_cpu,
   input  logic              reset,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic              cpu_mem_w,
   output logic [31:0]       cpu_rdata,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   input  logic [SW_W-1:0]   sw_in,
   output logic [SW_W-1:0]   led_out,
   output logic              INT
);

   localparam logic [7:0] OffLed    = 8'h00;
   localparam logic [7:0] OffSw     = 8'h04;
   localparam logic [7:0] OffCnt    = 8'h08;
   localparam logic [7:0] OffCmp    = 8'h0C;
   localparam logic [7:0] OffCtrl   = 8'h10;
   localparam logic [7:0] OffStatus = 8'h14;

   logic [SW_W-1:0] led_q, led_d;
   logic [SW_W-1:0] sw_meta_q, sw_meta_d;
   logic [SW_W-1:0] sw_sync_q, sw_sync_d;
   logic [31:0]     cnt_q, cnt_d;
   logic [31:0]     cmp_q, cmp_d;
   logic [2:0]      ctrl_q, ctrl_d;
   logic            pend_q, pend_d;

   logic        io_sel;
   logic        io_we;
   logic [7:0]  offset;
   logic        match;
   logic [31:0] io_rdata;

   // Address bits between the offset and the region nibble only alias.
   logic unused_addr;
   assign unused_addr = ^{cpu_addr[27:8], cpu_addr[1:0]};

   assign io_sel = (cpu_addr[31:28] == 4'hF);
   assign io_we  = cpu_mem_w & io_sel;
   assign offset = cpu_addr[7:0];
   assign match  = ctrl_q[0] & (cnt_q == cmp_q);

   assign ram_we    = cpu_mem_w & ~io_sel;
   assign ram_addr  = cpu_addr[RAM_AW+1:2];
   assign ram_wdata = cpu_wdata;

   assign led_out = led_q;
   assign INT     = pend_q & ctrl_q[2];

   always_comb begin
      led_d     = led_q;
      cmp_d     = cmp_q;
      ctrl_d    = ctrl_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      sw_meta_d = sw_in;
      sw_sync_d = sw_meta_q;

      if (io_we) begin
         case (offset)
            OffLed:  led_d  = cpu_wdata[SW_W-1:0];
            OffCmp:  cmp_d  = cpu_wdata;
            OffCtrl: ctrl_d = cpu_wdata[2:0];
            default: ;
         endcase
      end

      // CPU write beats reload, reload beats increment.
      if (io_we && (offset == OffCnt)) begin
         cnt_d = cpu_wdata;
      end else if (match && ctrl_q[1]) begin
         cnt_d = 32'd0;
      end else if (ctrl_q[0]) begin
         cnt_d = cnt_q + 32'd1;
      end

      // A match in the same cycle as a W1C wins so no event is lost.
      if (match) begin
         pend_d = 1'b1;
      end else if (io_we && (offset == OffStatus) && cpu_wdata[0]) begin
         pend_d = 1'b0;
      end
   end

   always_comb begin
      io_rdata = 32'd0;
      case (offset)
         OffLed:    io_rdata = 32'(led_q);
         OffSw:     io_rdata = 32'(sw_sync_q);
         OffCnt:    io_rdata = cnt_q;
         OffCmp:    io_rdata = cmp_q;
         OffCtrl:   io_rdata = {29'd0, ctrl_q};
         OffStatus: io_rdata = {31'd0, pend_q};
         default:   io_rdata = 32'd0;
      endcase
      cpu_rdata = io_sel ? io_rdata : ram_rdata;
   end

   always_ff @(posedge clk_cpu) begin
      if (reset) begin
         led_q     <= '0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
         cnt_q     <= 32'd0;
         cmp_q     <= 32'hFFFF_FFFF;
         ctrl_q    <= 3'd0;
         pend_q    <= 1'b0;
      end else begin
         led_q     <= led_d;
         sw_meta_q <= sw_meta_d;
         sw_sync_q <= sw_sync_d;
         cnt_q     <= cnt_d;
         cmp_q     <= cmp_d;
         ctrl_q    <= ctrl_d;
         pend_q    <= pend_d;
      end
   end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Self-checking bench for io_bus_ctrl: directed steps followed by random bus traffic,
// all outputs compared every cycle against a register-map reference model.
module tb_io_bus_ctrl;

   localparam int RAM_AW = 12;
   localparam int SW_W   = 16;

   logic              clk_cpu = 1'b0;
   logic              reset;
   logic [31:0]       cpu_addr;
   logic [31:0]       cpu_wdata;
   logic              cpu_mem_w;
   logic [31:0]       cpu_rdata;
   logic              ram_we;
   logic [RAM_AW-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;
   logic [SW_W-1:0]   sw_in;
   logic [SW_W-1:0]   led_out;
   logic              INT;

   always #5 clk_cpu = ~clk_cpu;

   io_bus_ctrl #(.RAM_AW(RAM_AW), .SW_W(SW_W)) dut (
      .clk_cpu   (clk_cpu),
      .reset     (reset),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_mem_w (cpu_mem_w),
      .cpu_rdata (cpu_rdata),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .sw_in     (sw_in),
      .led_out   (led_out),
      .INT       (INT)
   );

   int n_assert = 0;
   int n_fail   = 0;
   bit model_ok = 1'b0;

   // Reference model: the architectural I/O registers.
   logic [SW_W-1:0] m_led, m_sw1, m_sw2;
   logic [31:0]     m_cnt, m_cmp;
   logic [2:0]      m_ctrl;
   logic            m_pend;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_io_read(input logic [7:0] off);
      case (off)
         8'h00:   return 32'(m_led);
         8'h04:   return 32'(m_sw2);
         8'h08:   return m_cnt;
         8'h0C:   return m_cmp;
         8'h10:   return {29'd0, m_ctrl};
         8'h14:   return {31'd0, m_pend};
         default: return 32'd0;
      endcase
   endfunction

   task automatic check_outputs();
      logic io;
      io = (cpu_addr[31:28] == 4'hF);
      chk("ram_we", {31'd0, ram_we}, {31'd0, cpu_mem_w & ~io});
      chk("ram_addr", 32'(ram_addr), 32'((cpu_addr >> 2) % (1 << RAM_AW)));
      chk("ram_wdata", ram_wdata, cpu_wdata);
      chk("cpu_rdata", cpu_rdata, io ? model_io_read(cpu_addr[7:0]) : ram_rdata);
      chk("led_out", 32'(led_out), 32'(m_led));
      chk("INT", {31'd0, INT}, {31'd0, m_pend & m_ctrl[2]});
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic w,
                        input logic rst);
      cpu_addr  = a;
      cpu_wdata = wd;
      cpu_mem_w = w;
      reset     = rst;
      ram_rdata = $urandom;
      #2;
      if (model_ok) check_outputs();
   endtask

   // Advance one edge and update the model from the pre-edge values.
   task automatic tick();
      logic        wr;
      logic [7:0]  off;
      logic        hit;
      logic [31:0] n_cnt;
      logic        n_pend;
      @(posedge clk_cpu);
      if (reset) begin
         m_led = '0; m_sw1 = '0; m_sw2 = '0;
         m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_ctrl = 0; m_pend = 0;
      end else begin
         wr  = cpu_mem_w && (cpu_addr[31:28] == 4'hF);
         off = cpu_addr[7:0];
         hit = m_ctrl[0] && (m_cnt == m_cmp);
         if (wr && off == 8'h08)        n_cnt = cpu_wdata;
         else if (hit && m_ctrl[1])     n_cnt = 0;
         else if (m_ctrl[0])            n_cnt = m_cnt + 1;
         else                           n_cnt = m_cnt;
         if (hit)                                        n_pend = 1;
         else if (wr && off == 8'h14 && cpu_wdata[0])    n_pend = 0;
         else                                            n_pend = m_pend;
         if (wr && off == 8'h00) m_led  = cpu_wdata[SW_W-1:0];
         if (wr && off == 8'h0C) m_cmp  = cpu_wdata;
         if (wr && off == 8'h10) m_ctrl = cpu_wdata[2:0];
         m_sw2  = m_sw1;
         m_sw1  = sw_in;
         m_cnt  = n_cnt;
         m_pend = n_pend;
      end
      #1;
   endtask

   task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic w);
      drive(a, wd, w, 1'b0);
      tick();
   endtask

   initial begin
      sw_in = '0;
      #1;
      drive(32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      model_ok = 1'b1;

      // Reset state
      drive(32'hF000_000C, 32'h0, 1'b0, 1'b0);
      chk("rst_cmp", cpu_rdata, 32'hFFFF_FFFF);
      chk("rst_led", 32'(led_out), 32'h0);
      chk("rst_int", {31'd0, INT}, 32'h0);
      tick();

      // RAM path
      drive(32'h0000_0010, 32'h1234_5678, 1'b1, 1'b0);
      chk("t1_we", {31'd0, ram_we}, 32'h1);
      chk("t1_addr", 32'(ram_addr), 32'h4);
      chk("t1_wdata", ram_wdata, 32'h1234_5678);
      tick();
      drive(32'h0000_0010, 32'h0, 1'b0, 1'b0);
      ram_rdata = 32'hCAFE;
      #1;
      chk("t1_load", cpu_rdata, 32'hCAFE);
      tick();
      drive(32'hF000_0000, 32'h1234_5678, 1'b1, 1'b0);
      chk("t1_io_we", {31'd0, ram_we}, 32'h0);
      tick();

      // LED and switch synchronizer
      step(32'hF000_0000, 32'h0001_A5A5, 1'b1);
      chk("t2_led", 32'(led_out), 32'hA5A5);
      sw_in = 16'h00F0;
      drive(32'hF000_0004, 32'h0, 1'b0, 1'b0);
      chk("t2_sw0", cpu_rdata, 32'h0);
      tick();
      drive(32'hF000_0004, 32'h0, 1'b0, 1'b0);
      chk("t2_sw1", cpu_rdata, 32'h0);
      tick();
      drive(32'hF000_0004, 32'h0, 1'b0, 1'b0);
      chk("t2_sw2", cpu_rdata, 32'hF0);
      tick();

      // Auto-reload timer with interrupt
      step(32'hF000_000C, 32'd5, 1'b1);
      step(32'hF000_0010, 32'h7, 1'b1);
      for (int i = 0; i < 6; i++) begin
         drive(32'hF000_0008, 32'h0, 1'b0, 1'b0);
         chk("t3_cnt", cpu_rdata, 32'(i));
         chk("t3_int_lo", {31'd0, INT}, 32'h0);
         tick();
      end
      drive(32'hF000_0008, 32'h0, 1'b0, 1'b0);
      chk("t3_int_hi", {31'd0, INT}, 32'h1);
      chk("t3_reload", cpu_rdata, 32'h0);
      tick();
      step(32'hF000_0014, 32'h1, 1'b1);
      drive(32'hF000_0014, 32'h0, 1'b0, 1'b0);
      chk("t3_w1c", {31'd0, INT}, 32'h0);
      tick();
      for (int i = 0; i < 6; i++) step(32'hF000_0008, 32'h0, 1'b0);

      // Free-running wrap, W1C colliding with match
      step(32'hF000_0010, 32'h5, 1'b1);
      step(32'hF000_0008, 32'hFFFF_FFFE, 1'b1);
      step(32'hF000_000C, 32'hFFFF_FFFF, 1'b1);
      step(32'hF000_0014, 32'h1, 1'b1);
      drive(32'hF000_0008, 32'h0, 1'b0, 1'b0);
      chk("t4_pend_kept", {31'd0, INT}, 32'h1);
      chk("t4_wrap", cpu_rdata, 32'h0);
      tick();

      // Counter write priority and unmapped offset
      step(32'hF000_0008, 32'd100, 1'b1);
      drive(32'hF000_0008, 32'h0, 1'b0, 1'b0);
      chk("t5_cnt_wr", cpu_rdata, 32'd100);
      tick();
      step(32'hF123_4520, 32'hFFFF_FFFF, 1'b1);
      drive(32'hF000_0020, 32'h0, 1'b0, 1'b0);
      chk("t5_unmapped", cpu_rdata, 32'h0);
      tick();

      // Reset mid-operation discards the concurrent store
      step(32'hF000_0000, 32'h0000_FFFF, 1'b1);
      chk("t6_int_pre", {31'd0, INT}, 32'h1);
      drive(32'hF000_000C, 32'h0, 1'b1, 1'b1);
      tick();
      drive(32'hF000_000C, 32'h0, 1'b0, 1'b0);
      chk("t6_cmp", cpu_rdata, 32'hFFFF_FFFF);
      chk("t6_led", 32'(led_out), 32'h0);
      chk("t6_int", {31'd0, INT}, 32'h0);
      tick();

      // Random traffic biased toward timer events
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] a, wd;
         logic [7:0]  off;
         logic        w, rst;
         case ($urandom_range(0, 7))
            0: off = 8'h00;
            1: off = 8'h04;
            2: off = 8'h08;
            3: off = 8'h0C;
            4: off = 8'h10;
            5: off = 8'h14;
            6: off = 8'h20;
            default: off = 8'($urandom);
         endcase
         if ($urandom_range(0, 3) != 0) a = {4'hF, 20'($urandom), off};
         else                           a = {4'($urandom_range(0, 14)), 28'($urandom)};
         wd = $urandom;
         if (off == 8'h08 || off == 8'h0C) wd = $urandom_range(0, 12);
         w   = ($urandom_range(0, 3) == 0);
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 9) == 0) sw_in = 16'($urandom);
         drive(a, wd, w, rst);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
